// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand and result handshake bundle for serial_adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             valid_out;
  logic             ready_in;

  modport master (
    output a_in, b_in, cin_in, valid_in, ready_in,
    input  ready_out, sum_out, carry_out, valid_out
  );

  modport slave (
    input  a_in, b_in, cin_in, valid_in, ready_in,
    output ready_out, sum_out, carry_out, valid_out
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one bit per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  serial_adder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

  // Full adder as two half adders joined by an OR on the carries
  assign ha0_s = a_q[0] ^ b_q[0];
  assign ha0_c = a_q[0] & b_q[0];
  assign ha1_s = ha0_s ^ carry_q;
  assign ha1_c = ha0_s & carry_q;
  assign fa_c  = ha0_c | ha1_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ready_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.ready_out = (state_q == IDLE);
  assign bus.valid_out = (state_q == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 16
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  i8 ();
  serial_adder_if #(.WIDTH(16)) i16 ();

  serial_adder #(.WIDTH(8))  u8  (.clk_in(clk), .rst_in(rst), .bus(i8));
  serial_adder #(.WIDTH(16)) u16 (.clk_in(clk), .rst_in(rst), .bus(i16));

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input bit wide, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic v);
    if (wide) begin
      i16.a_in = a[15:0]; i16.b_in = b[15:0]; i16.cin_in = cin; i16.valid_in = v;
    end else begin
      i8.a_in = a[7:0]; i8.b_in = b[7:0]; i8.cin_in = cin; i8.valid_in = v;
    end
  endtask

  task automatic set_rdy(input bit wide, input logic r);
    if (wide) i16.ready_in = r;
    else      i8.ready_in = r;
  endtask

  // {valid, carry, zero-extended sum}
  function automatic logic [33:0] res(input bit wide);
    if (wide) return {i16.valid_out, i16.carry_out, 16'h0, i16.sum_out};
    return {i8.valid_out, i8.carry_out, 24'h0, i8.sum_out};
  endfunction

  function automatic logic rdy(input bit wide);
    return wide ? i16.ready_out : i8.ready_out;
  endfunction

  function automatic logic [32:0] model(input bit wide, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [31:0] m;
    logic [33:0] full;
    m    = wide ? 32'h0000_FFFF : 32'h0000_00FF;
    full = {2'b00, a & m} + {2'b00, b & m} + {33'h0, cin};
    return {(wide ? full[16] : full[8]), full[31:0] & m};
  endfunction

  task automatic do_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input int stall, input bit busy);
    int w;
    int lat;
    int t;
    logic [33:0] snap;
    logic [33:0] now;
    w = wide ? 16 : 8;
    t = 0;
    while (!rdy(wide) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 64'(rdy(wide)), 64'd1);
    set_ops(wide, a, b, cin, 1'b1);
    set_rdy(wide, stall == 0);
    @(posedge clk);
    sb.push_back(model(wide, a, b, cin));
    @(negedge clk);
    check("busy_ready", 64'(rdy(wide)), 64'd0);
    if (busy) set_ops(wide, 32'h11, 32'h11, 1'b1, 1'b1);
    else      set_ops(wide, 32'h0, 32'h0, 1'b0, 1'b0);
    lat  = 0;
    snap = res(wide);
    while (!snap[33] && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      snap = res(wide);
    end
    set_ops(wide, 32'h0, 32'h0, 1'b0, 1'b0);
    check("latency", 64'(lat), 64'(w));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold", 64'(res(wide)), 64'(snap));
    end
    set_rdy(wide, 1'b1);
    snap = res(wide);
    check("valid", 64'(snap[33]), 64'd1);
    if (sb.size() == 0) check("sb_underflow", 64'd0, 64'd1);
    else                check("result", 64'(snap[32:0]), 64'(sb.pop_front()));
    @(posedge clk);
    @(negedge clk);
    set_rdy(wide, 1'b0);
    now = res(wide);
    check("idle_valid", 64'(now[33]), 64'd0);
    check("idle_ready", 64'(rdy(wide)), 64'd1);
    @(negedge clk);
    now = res(wide);
    check("idle_stable", 64'(now[32:0]), 64'(snap[32:0]));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] r;
    int vcount;
    rst = 1'b1;
    set_ops(1'b0, 32'hFF, 32'hFF, 1'b1, 1'b1);
    set_ops(1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1);
    set_rdy(1'b0, 1'b0);
    set_rdy(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state8", 64'(res(1'b0)), 64'd0);
    check("rst_ready8", 64'(rdy(1'b0)), 64'd1);
    check("rst_state16", 64'(res(1'b1)), 64'd0);
    set_ops(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    set_ops(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 32'h5A, 32'h3C, 1'b0, 0, 1'b0);
    do_op(1'b0, 32'hFF, 32'h01, 1'b0, 2, 1'b0);
    do_op(1'b0, 32'hFF, 32'hFF, 1'b1, 5, 1'b0);
    do_op(1'b0, 32'h20, 32'h30, 1'b0, 1, 1'b1);
    do_op(1'b1, 32'hFFFF, 32'h0001, 1'b0, 0, 1'b1);

    // Reset lands on the 4th shift edge while new operands are offered
    set_ops(1'b0, 32'h5A, 32'h3C, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ops(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_ops(1'b0, 32'hFF, 32'hFF, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs", 64'(res(1'b0)), 64'd0);
    check("rst_mid_ready", 64'(rdy(1'b0)), 64'd1);
    rst = 1'b0;
    set_ops(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vcount = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      r = res(1'b0);
      if (r[33]) vcount++;
    end
    check("no_valid_after_rst", 64'(vcount), 64'd0);
    do_op(1'b0, 32'h01, 32'h02, 1'b0, 0, 1'b0);

    for (int k = 0; k < 1000; k++)
      do_op(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 1000; k++)
      do_op(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
